ddr3_avl_arbiter: RTL and testbench
===================================

DDR3_AVL_ARBITER -- requirements
Module: ddr3_avl_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH_LOG2, default 4, meaning log2 of the read-return tag FIFO depth (16 entries).
REQ-002 SHALL have ports: sodimm1_ddr3_avl_clk input 1 clock; sodimm1_ddr3_avl_reset input 1, asynchronous, active-high.
REQ-003 SHALL have, per requester N in {0,1}, these ports:
- pN_read_req in 1; pN_write_req in 1; pN_burstbegin in 1
- pN_addr in 26; pN_size in 3 (beats); pN_wdata in 128
- pN_ready out 1, beat accepted; pN_rdata_valid out 1; pN_rdata out 128
REQ-004 SHALL have downstream controller ports:
- avl_ready in 1
- avl_read_req, avl_write_req, avl_burstbegin out 1 each
- avl_addr out 26; avl_size out 3; avl_wdata out 128
- avl_rdata_valid in 1; avl_rdata in 128

Function
REQ-005 SHALL have states IDLE and WR_BURST; it SHALL track grant owner (port 0 or 1) and remaining write beats (3-bit).
REQ-006 In IDLE, a port is requesting when read_req or write_req is high; the winner SHALL be selected combinationally in the same cycle, and the loser's pN_ready SHALL be 0.
REQ-007 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; last-grant SHALL update only on an accepted command beat.
REQ-008 The winner's command, address, size, wdata and burstbegin SHALL drive the avl_* outputs combinationally; avl_* request outputs SHALL be 0 when nothing is granted.
REQ-009 winner pN_ready SHALL equal avl_ready AND NOT (read_req AND tag_full); when the tag FIFO is full, avl_read_req SHALL be suppressed.
REQ-010 An accepted read (read_req & ready) SHALL push {port, size} into the tag FIFO and leave the block in IDLE; a read is one command beat.
REQ-011 An accepted write first beat with size>1 SHALL enter WR_BURST, lock the grant and set remaining = size-1.
REQ-011a In WR_BURST, only the locked port is granted; each beat accepted with avl_ready SHALL decrement remaining, and remaining reaching 0 SHALL return to IDLE.
REQ-012 In WR_BURST, avl_burstbegin SHALL be 0, avl_write_req SHALL follow the locked port's write_req, and the other port's read/write requests SHALL be held off.
REQ-013 A size of 0 SHALL be treated as 1 beat for both burst counting and tag counting.
REQ-014 Read data routing: avl_rdata SHALL fan out to both pN_rdata; pN_rdata_valid SHALL equal avl_rdata_valid AND (head tag port == N), with zero added latency.
REQ-015 A 3-bit beat counter SHALL count returned beats; when it reaches the head tag's size, the head SHALL be popped and the counter cleared in that cycle.
REQ-016 A tag-FIFO push and pop in the same cycle SHALL both take effect; if the FIFO is full, a push in the same cycle as a pop SHALL still be refused (full is registered).
REQ-017 avl_rdata_valid arriving with an empty tag FIFO SHALL be dropped: no pN_rdata_valid is asserted, and error_ovf (a sticky status output of width 1) SHALL set.

Reset
REQ-018 Reset SHALL immediately clear: state to IDLE, last-grant to port 1 (so port 0 wins first), remaining, beat counter, tag FIFO pointers and error_ovf.
REQ-019 While reset is asserted, all pN_ready, pN_rdata_valid and avl_* request outputs SHALL be 0.
REQ-020 Reset mid-burst SHALL abandon the burst; outstanding read tags SHALL be discarded with no completion.

Configuration
REQ-021 With macro DDR3_ARB_FIXED_PRIO_EN defined, port 0 (display fetch) SHALL always win in IDLE, and last-grant SHALL be unused.
REQ-022 Without DDR3_ARB_FIXED_PRIO_EN, round-robin per REQ-007 SHALL apply; WR_BURST locking is identical in both builds.

Verification
REQ-023 Both ports request reads of size 4 continuously with avl_ready=1: grants SHALL alternate 1:1 starting with port 0, with returned data routed in issue order.
REQ-024 Port 1 writes size 4 at addr 0x100 while port 0 raises read_req after beat 1: all 4 write beats (0x100..0x103) SHALL complete before port 0 gets pN_ready.
REQ-025 avl_ready toggles randomly during a size-7 write: exactly 7 beats SHALL be accepted, and state SHALL return to IDLE after the 7th.
REQ-026 Port 0 issues 16 reads with avl_rdata_valid held low: the 17th read SHALL see p0_ready=0; after the first tag's data returns, it SHALL be accepted.
REQ-027 With DDR3_ARB_FIXED_PRIO_EN defined and both ports requesting continuously: port 1 SHALL never be granted; with port 0 idle, port 1 SHALL be granted in the same cycle.
REQ-028 Reset asserted during a WR_BURST with 3 tags outstanding, then released: outputs SHALL be idle, error_ovf=0, and a stray avl_rdata_valid SHALL set error_ovf=1.

Source files
------------

// File: rtl/ddr3_avl_arbiter_if.sv
// Bundle of requester-side (p0/p1) and controller-side (avl) signals for the
// two-port DDR3 Avalon arbiter; the arbiter uses the slave modport.
interface ddr3_avl_arbiter_if;
  logic         p0_read_req, p0_write_req, p0_burstbegin;
  logic [25:0]  p0_addr;
  logic [2:0]   p0_size;
  logic [127:0] p0_wdata;
  logic         p0_ready, p0_rdata_valid;
  logic [127:0] p0_rdata;

  logic         p1_read_req, p1_write_req, p1_burstbegin;
  logic [25:0]  p1_addr;
  logic [2:0]   p1_size;
  logic [127:0] p1_wdata;
  logic         p1_ready, p1_rdata_valid;
  logic [127:0] p1_rdata;

  logic         avl_ready;
  logic         avl_read_req, avl_write_req, avl_burstbegin;
  logic [25:0]  avl_addr;
  logic [2:0]   avl_size;
  logic [127:0] avl_wdata;
  logic         avl_rdata_valid;
  logic [127:0] avl_rdata;
  logic         error_ovf;

  modport slave (
    input  p0_read_req, p0_write_req, p0_burstbegin, p0_addr, p0_size, p0_wdata,
    output p0_ready, p0_rdata_valid, p0_rdata,
    input  p1_read_req, p1_write_req, p1_burstbegin, p1_addr, p1_size, p1_wdata,
    output p1_ready, p1_rdata_valid, p1_rdata,
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_read_req, avl_write_req, avl_burstbegin, avl_addr, avl_size, avl_wdata,
    output error_ovf
  );

  modport master (
    output p0_read_req, p0_write_req, p0_burstbegin, p0_addr, p0_size, p0_wdata,
    input  p0_ready, p0_rdata_valid, p0_rdata,
    output p1_read_req, p1_write_req, p1_burstbegin, p1_addr, p1_size, p1_wdata,
    input  p1_ready, p1_rdata_valid, p1_rdata,
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_read_req, avl_write_req, avl_burstbegin, avl_addr, avl_size, avl_wdata,
    input  error_ovf
  );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Two-port Avalon arbiter in front of a DDR3 controller: round-robin command grant,
// write-burst locking and tag-FIFO read-return routing. DDR3_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module ddr3_avl_arbiter #(
  parameter int TAG_DEPTH_LOG2 = 4
) (
  input logic               sodimm1_ddr3_avl_clk,
  input logic               sodimm1_ddr3_avl_reset,
  ddr3_avl_arbiter_if.slave bus
);
  localparam int TAG_DEPTH = 1 << TAG_DEPTH_LOG2;

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_owner;
  logic [2:0]              r_remain, r_beat_cnt;
  logic                    r_error_ovf;
  logic [TAG_DEPTH_LOG2:0] r_wptr, r_rptr;
  logic                    r_tag_port [TAG_DEPTH];
  logic [2:0]              r_tag_size [TAG_DEPTH];
`ifndef DDR3_ARB_FIXED_PRIO_EN
  logic                    r_last;
`endif

  logic       w_rst, w_req0, w_req1, w_gnt, w_gvld;
  logic       w_sel_rd, w_sel_wr, w_sel_bb, w_rdy, w_acc, w_push, w_pop;
  logic       w_tag_full, w_tag_empty, w_head_port, w_rd_hit;
  logic [2:0] w_sel_size, w_head_size, w_beat_inc;

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

  assign w_rst  = sodimm1_ddr3_avl_reset;
  assign w_req0 = bus.p0_read_req | bus.p0_write_req;
  assign w_req1 = bus.p1_read_req | bus.p1_write_req;

  // Full is derived from registered pointers only, so a same-cycle pop cannot make room.
  assign w_tag_empty = (r_wptr == r_rptr);
  assign w_tag_full  = (r_wptr[TAG_DEPTH_LOG2] != r_rptr[TAG_DEPTH_LOG2]) &&
                       (r_wptr[TAG_DEPTH_LOG2-1:0] == r_rptr[TAG_DEPTH_LOG2-1:0]);
  assign w_head_port = r_tag_port[r_rptr[TAG_DEPTH_LOG2-1:0]];
  assign w_head_size = eff_size(r_tag_size[r_rptr[TAG_DEPTH_LOG2-1:0]]);

  always_comb begin
    w_state_nxt = r_state;
    w_gvld      = 1'b0;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        w_gvld = w_req0 | w_req1;
`ifdef DDR3_ARB_FIXED_PRIO_EN
        w_gnt  = ~w_req0;
`else
        w_gnt  = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif
      end
      WR_BURST: begin
        w_gvld = 1'b1;
        w_gnt  = r_owner;
      end
      default: ;
    endcase

    w_sel_wr   = w_gnt ? bus.p1_write_req : bus.p0_write_req;
    w_sel_rd   = (r_state == IDLE) & ~w_sel_wr & (w_gnt ? bus.p1_read_req : bus.p0_read_req);
    w_sel_bb   = (r_state == IDLE) & (w_gnt ? bus.p1_burstbegin : bus.p0_burstbegin);
    w_sel_size = eff_size(w_gnt ? bus.p1_size : bus.p0_size);
    w_rdy      = ~w_rst & w_gvld & bus.avl_ready & ~(w_sel_rd & w_tag_full);
    w_acc      = w_rdy & (w_sel_rd | w_sel_wr);

    case (r_state)
      IDLE:     if (w_acc && w_sel_wr && (w_sel_size > 3'd1)) w_state_nxt = WR_BURST;
      WR_BURST: if (w_acc && (r_remain == 3'd1))             w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_push     = w_acc & w_sel_rd;
  assign w_rd_hit   = ~w_rst & bus.avl_rdata_valid & ~w_tag_empty;
  assign w_beat_inc = r_beat_cnt + 3'd1;
  assign w_pop      = w_rd_hit & (w_beat_inc == w_head_size);

  assign bus.avl_read_req   = ~w_rst & w_gvld & w_sel_rd & ~w_tag_full;
  assign bus.avl_write_req  = ~w_rst & w_gvld & w_sel_wr;
  assign bus.avl_burstbegin = ~w_rst & w_gvld & w_sel_bb;
  assign bus.avl_addr       = w_gnt ? bus.p1_addr  : bus.p0_addr;
  assign bus.avl_size       = w_gnt ? bus.p1_size  : bus.p0_size;
  assign bus.avl_wdata      = w_gnt ? bus.p1_wdata : bus.p0_wdata;
  assign bus.p0_ready       = w_rdy & ~w_gnt;
  assign bus.p1_ready       = w_rdy &  w_gnt;
  assign bus.p0_rdata_valid = w_rd_hit & ~w_head_port;
  assign bus.p1_rdata_valid = w_rd_hit &  w_head_port;
  assign bus.p0_rdata       = bus.avl_rdata;
  assign bus.p1_rdata       = bus.avl_rdata;
  assign bus.error_ovf      = r_error_ovf;

  always_ff @(posedge sodimm1_ddr3_avl_clk or posedge sodimm1_ddr3_avl_reset) begin
    if (sodimm1_ddr3_avl_reset) r_state <= IDLE;
    else                        r_state <= w_state_nxt;
  end

  always_ff @(posedge sodimm1_ddr3_avl_clk or posedge sodimm1_ddr3_avl_reset) begin
    if (sodimm1_ddr3_avl_reset) begin
      r_owner     <= 1'b0;
      r_remain    <= 3'd0;
      r_beat_cnt  <= 3'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_error_ovf <= 1'b0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
`ifndef DDR3_ARB_FIXED_PRIO_EN
      if (w_acc) r_last <= w_gnt;
`endif
      if (r_state == IDLE && w_state_nxt == WR_BURST) begin
        r_owner  <= w_gnt;
        r_remain <= w_sel_size - 3'd1;
      end else if (r_state == WR_BURST && w_acc) begin
        r_remain <= r_remain - 3'd1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_rd_hit) r_beat_cnt <= w_pop ? 3'd0 : w_beat_inc;
      if (bus.avl_rdata_valid && w_tag_empty) r_error_ovf <= 1'b1;
    end
  end

  // Tag payload is plain storage; validity is carried by the pointers.
  always_ff @(posedge sodimm1_ddr3_avl_clk) begin
    if (w_push) begin
      r_tag_port[r_wptr[TAG_DEPTH_LOG2-1:0]] <= w_gnt;
      r_tag_size[r_wptr[TAG_DEPTH_LOG2-1:0]] <= w_gnt ? bus.p1_size : bus.p0_size;
    end
  end
endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Scoreboard bench for ddr3_avl_arbiter: expected commands and read-return beats are
// queued as stimulus is issued and compared when the arbiter presents them.
module tb_ddr3_avl_arbiter;
  typedef struct { bit wr; bit port; bit bb; logic [25:0] addr; logic [2:0] size; logic [127:0] wdata; } cmd_t;
  typedef struct { bit port; logic [127:0] data; } rd_t;
  typedef struct { logic [25:0] addr; logic [2:0] size; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ddr3_avl_arbiter_if bus();

  ddr3_avl_arbiter dut (
    .sodimm1_ddr3_avl_clk   (clk),
    .sodimm1_ddr3_avl_reset (rst),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  rsp_t resp_q[$];
  int   n_chk = 0, n_pass = 0;
  bit   resp_en = 1'b0;
  int   stray_req = 0, stray_done = 0, rbeat = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int eff(input logic [2:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [127:0] mk_data(input logic [25:0] a, input int b);
    return {64'hA5A55A5A00000000, 6'd0, a, 29'd0, 3'(b)};
  endfunction

  task automatic push_cmd(input bit wr, input bit port, input bit bb, input logic [25:0] addr,
                          input logic [2:0] size, input logic [127:0] wdata);
    cmd_t c;
    c.wr = wr; c.port = port; c.bb = bb; c.addr = addr; c.size = size; c.wdata = wdata;
    exp_cmd.push_back(c);
  endtask

  task automatic step(output bit a0, output bit a1);
    @(negedge clk);
    a0 = bus.p0_ready && (bus.p0_read_req || bus.p0_write_req);
    a1 = bus.p1_ready && (bus.p1_read_req || bus.p1_write_req);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_rd.size() != 0) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 128'(exp_cmd.size() + exp_rd.size()), 128'd0);
  endtask

  // Command and read-return monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.avl_ready && (bus.avl_read_req || bus.avl_write_req)) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected", 128'd1, 128'd0);
        else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_wr", 128'(bus.avl_write_req), 128'(e.wr));
          check("cmd_rd", 128'(bus.avl_read_req), 128'(!e.wr));
          check("cmd_port_ready", 128'({bus.p1_ready, bus.p0_ready}), e.port ? 128'd2 : 128'd1);
          check("cmd_addr", 128'(bus.avl_addr), 128'(e.addr));
          check("cmd_size", 128'(bus.avl_size), 128'(e.size));
          check("cmd_bb", 128'(bus.avl_burstbegin), 128'(e.bb));
          if (e.wr) check("cmd_wdata", bus.avl_wdata, e.wdata);
          else begin
            rsp_t r;
            r.addr = e.addr; r.size = e.size;
            resp_q.push_back(r);
            for (int b = 0; b < eff(e.size); b++) begin
              rd_t d;
              d.port = e.port; d.data = mk_data(e.addr, b);
              exp_rd.push_back(d);
            end
          end
        end
      end
      if (bus.p0_rdata_valid || bus.p1_rdata_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 128'd1, 128'd0);
        else begin
          rd_t d;
          d = exp_rd.pop_front();
          check("rd_route", 128'({bus.p1_rdata_valid, bus.p0_rdata_valid}), d.port ? 128'd2 : 128'd1);
          check("rd_data", d.port ? bus.p1_rdata : bus.p0_rdata, d.data);
        end
      end
    end
  end

  // Memory responder: one beat per cycle, driven 2 time units after the edge
  always begin
    @(posedge clk); #2;
    bus.avl_rdata_valid = 1'b0;
    bus.avl_rdata       = '0;
    if (rst) rbeat = 0;
    else if (stray_req != stray_done) begin
      bus.avl_rdata_valid = 1'b1;
      bus.avl_rdata       = 128'hDEAD;
      stray_done++;
    end else if (resp_en && resp_q.size() > 0) begin
      bus.avl_rdata_valid = 1'b1;
      bus.avl_rdata       = mk_data(resp_q[0].addr, rbeat);
      rbeat++;
      if (rbeat == eff(resp_q[0].size)) begin
        void'(resp_q.pop_front());
        rbeat = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, a1;
    int c0, c1;
    bus.p0_read_req = 1'b1; bus.p0_write_req = 1'b0; bus.p0_burstbegin = 1'b1;
    bus.p0_addr = '0; bus.p0_size = 3'd1; bus.p0_wdata = '0;
    bus.p1_read_req = 1'b0; bus.p1_write_req = 1'b1; bus.p1_burstbegin = 1'b1;
    bus.p1_addr = '0; bus.p1_size = 3'd1; bus.p1_wdata = '0;
    bus.avl_ready = 1'b1;

    // Reset: requests present but every handshake output must be gated
    repeat (2) @(posedge clk);
    #1;
    check("rst_p0_ready", 128'(bus.p0_ready), 128'd0);
    check("rst_p1_ready", 128'(bus.p1_ready), 128'd0);
    check("rst_avl_rd", 128'(bus.avl_read_req), 128'd0);
    check("rst_avl_wr", 128'(bus.avl_write_req), 128'd0);
    check("rst_ovf", 128'(bus.error_ovf), 128'd0);
    bus.p0_read_req = 1'b0; bus.p1_write_req = 1'b0;
    rst = 1'b0;
    resp_en = 1'b1;

    // T1: both ports stream size-4 reads; grants alternate starting at port 0
    for (int k = 0; k < 8; k++)
      push_cmd(1'b0, k[0], 1'b1, (k[0] ? 26'h2000 : 26'h1000) + 26'(k / 2), 3'd4, '0);
    bus.p0_read_req = 1'b1; bus.p0_addr = 26'h1000; bus.p0_size = 3'd4; bus.p0_burstbegin = 1'b1;
    bus.p1_read_req = 1'b1; bus.p1_addr = 26'h2000; bus.p1_size = 3'd4; bus.p1_burstbegin = 1'b1;
    bus.p1_write_req = 1'b0;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 100 && (c0 < 4 || c1 < 4); c++) begin
      step(a0, a1);
      if (a0) begin c0++; bus.p0_addr = 26'h1000 + 26'(c0); if (c0 == 4) bus.p0_read_req = 1'b0; end
      if (a1) begin c1++; bus.p1_addr = 26'h2000 + 26'(c1); if (c1 == 4) bus.p1_read_req = 1'b0; end
    end
    check("t1_issued", 128'(c0 + c1), 128'd8);
    wait_drain(200);

    // T2: port 1 write burst of 4 holds off a port 0 read raised after beat 1
    for (int i = 0; i < 4; i++)
      push_cmd(1'b1, 1'b1, i == 0, 26'h100 + 26'(i), 3'd4, 128'h11110000 + 128'(i));
    push_cmd(1'b0, 1'b0, 1'b1, 26'h300, 3'd1, '0);
    bus.p1_write_req = 1'b1; bus.p1_addr = 26'h100; bus.p1_size = 3'd4;
    bus.p1_wdata = 128'h11110000; bus.p1_burstbegin = 1'b1;
    bus.p0_addr = 26'h300; bus.p0_size = 3'd1;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 50 && (c0 < 1 || c1 < 4); c++) begin
      step(a0, a1);
      if (c1 < 4 && bus.p0_read_req) check("t2_p0_held", 128'(a0), 128'd0);
      if (a0) begin c0++; bus.p0_read_req = 1'b0; end
      if (a1) begin
        c1++;
        bus.p1_addr = 26'h100 + 26'(c1); bus.p1_wdata = 128'h11110000 + 128'(c1);
        if (c1 == 1) bus.p0_read_req = 1'b1;
        if (c1 == 4) bus.p1_write_req = 1'b0;
      end
    end
    wait_drain(100);

    // T3: size-7 write under random avl_ready; port 1 read waits then wins at once
    for (int i = 0; i < 7; i++)
      push_cmd(1'b1, 1'b0, i == 0, 26'h400 + 26'(i), 3'd7, 128'h77000000 + 128'(i));
    push_cmd(1'b0, 1'b1, 1'b1, 26'h450, 3'd1, '0);
    bus.p0_write_req = 1'b1; bus.p0_addr = 26'h400; bus.p0_size = 3'd7;
    bus.p0_wdata = 128'h77000000; bus.p0_burstbegin = 1'b1;
    bus.p1_addr = 26'h450; bus.p1_size = 3'd1;
    c0 = 0;
    for (int c = 0; c < 200 && c0 < 7; c++) begin
      step(a0, a1);
      check("t3_p1_held", 128'(a1), 128'd0);
      if (a0) begin
        c0++;
        bus.p0_burstbegin = 1'b0;
        bus.p0_addr = 26'h400 + 26'(c0); bus.p0_wdata = 128'h77000000 + 128'(c0);
        if (c0 == 2) bus.p1_read_req = 1'b1;
      end
      bus.avl_ready = (c0 == 7) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    bus.p0_write_req = 1'b0;
    check("t3_beats", 128'(c0), 128'd7);
    step(a0, a1);
    check("t3_idle_grant", 128'(a1), 128'd1);
    bus.p1_read_req = 1'b0;
    wait_drain(100);

    // T4: 16 outstanding reads fill the tag FIFO; the 17th waits for a pop
    resp_en = 1'b0;
    for (int i = 0; i < 17; i++) push_cmd(1'b0, 1'b0, 1'b1, 26'h500 + 26'(i), 3'd1, '0);
    bus.p0_read_req = 1'b1; bus.p0_addr = 26'h500; bus.p0_size = 3'd1; bus.p0_burstbegin = 1'b1;
    c0 = 0;
    for (int c = 0; c < 60 && c0 < 16; c++) begin
      step(a0, a1);
      if (a0) begin c0++; bus.p0_addr = 26'h500 + 26'(c0); end
    end
    check("t4_issued", 128'(c0), 128'd16);
    for (int c = 0; c < 4; c++) begin
      step(a0, a1);
      check("t4_full_ready", 128'(a0), 128'd0);
    end
    resp_en = 1'b1;
    step(a0, a1);
    check("t4_pop_cycle_ready", 128'(a0), 128'd0);
    step(a0, a1);
    check("t4_17th_ready", 128'(a0), 128'd1);
    bus.p0_read_req = 1'b0;
    wait_drain(200);

    // T5: size 0 is a single beat for both reads and writes
    push_cmd(1'b0, 1'b1, 1'b1, 26'h600, 3'd0, '0);
    push_cmd(1'b1, 1'b0, 1'b1, 26'h700, 3'd0, 128'hBEEF);
    push_cmd(1'b0, 1'b1, 1'b1, 26'h601, 3'd1, '0);
    bus.p1_read_req = 1'b1; bus.p1_addr = 26'h600; bus.p1_size = 3'd0;
    a1 = 1'b0;
    for (int c = 0; c < 10 && !a1; c++) step(a0, a1);
    bus.p1_read_req = 1'b0;
    bus.p0_write_req = 1'b1; bus.p0_addr = 26'h700; bus.p0_size = 3'd0;
    bus.p0_wdata = 128'hBEEF; bus.p0_burstbegin = 1'b1;
    a0 = 1'b0;
    for (int c = 0; c < 10 && !a0; c++) step(a0, a1);
    bus.p0_write_req = 1'b0;
    bus.p1_read_req = 1'b1; bus.p1_addr = 26'h601; bus.p1_size = 3'd1;
    step(a0, a1);
    check("t5_size0_idle", 128'(a1), 128'd1);
    bus.p1_read_req = 1'b0;
    wait_drain(100);
    check("ovf_clean", 128'(bus.error_ovf), 128'd0);

    // T6: reset mid-burst with 3 read tags outstanding
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 1'b0, 1'b1, 26'h800 + 26'(i), 3'd2, '0);
    bus.p0_read_req = 1'b1; bus.p0_addr = 26'h800; bus.p0_size = 3'd2;
    c0 = 0;
    for (int c = 0; c < 30 && c0 < 3; c++) begin
      step(a0, a1);
      if (a0) begin c0++; bus.p0_addr = 26'h800 + 26'(c0); if (c0 == 3) bus.p0_read_req = 1'b0; end
    end
    for (int i = 0; i < 2; i++)
      push_cmd(1'b1, 1'b1, i == 0, 26'h900 + 26'(i), 3'd4, 128'h9900 + 128'(i));
    bus.p1_write_req = 1'b1; bus.p1_addr = 26'h900; bus.p1_size = 3'd4;
    bus.p1_wdata = 128'h9900; bus.p1_burstbegin = 1'b1;
    c1 = 0;
    for (int c = 0; c < 30 && c1 < 2; c++) begin
      step(a0, a1);
      if (a1) begin
        c1++; bus.p1_burstbegin = 1'b0;
        bus.p1_addr = 26'h900 + 26'(c1); bus.p1_wdata = 128'h9900 + 128'(c1);
      end
    end
    rst = 1'b1;
    bus.p0_read_req = 1'b1;
    #1;
    exp_rd.delete();
    resp_q.delete();
    check("t6_rst_p0_ready", 128'(bus.p0_ready), 128'd0);
    check("t6_rst_p1_ready", 128'(bus.p1_ready), 128'd0);
    check("t6_rst_avl_wr", 128'(bus.avl_write_req), 128'd0);
    check("t6_rst_avl_rd", 128'(bus.avl_read_req), 128'd0);
    @(posedge clk); #1;
    bus.p0_read_req = 1'b0; bus.p1_write_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_rd", 128'(bus.avl_read_req), 128'd0);
    check("t6_idle_wr", 128'(bus.avl_write_req), 128'd0);
    check("t6_ovf_clear", 128'(bus.error_ovf), 128'd0);
    @(posedge clk); #1;
    stray_req++;
    @(negedge clk);
    check("t6_stray_valid", 128'({bus.p1_rdata_valid, bus.p0_rdata_valid}), 128'd0);
    @(posedge clk); #1;
    check("t6_ovf_set", 128'(bus.error_ovf), 128'd1);

    // Burst abandoned and last-grant back at port 1: port 0 wins the tie
    push_cmd(1'b1, 1'b0, 1'b1, 26'hA00, 3'd1, 128'hA0);
    push_cmd(1'b1, 1'b1, 1'b1, 26'hA10, 3'd1, 128'hA1);
    bus.p0_write_req = 1'b1; bus.p0_addr = 26'hA00; bus.p0_size = 3'd1; bus.p0_wdata = 128'hA0; bus.p0_burstbegin = 1'b1;
    bus.p1_write_req = 1'b1; bus.p1_addr = 26'hA10; bus.p1_size = 3'd1; bus.p1_wdata = 128'hA1; bus.p1_burstbegin = 1'b1;
    step(a0, a1);
    check("t6_first_grant", 128'({a1, a0}), 128'd1);
    bus.p0_write_req = 1'b0;
    step(a0, a1);
    check("t6_second_grant", 128'(a1), 128'd1);
    bus.p1_write_req = 1'b0;
    wait_drain(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
